// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: folds prefix bytes (E0/F0/E1) into make/break
// events, queues them in a show-ahead FIFO and tracks the held state of watched keys.
module ps2_key_decoder #(
  parameter int                     FIFO_DEPTH     = 4,
  parameter int                     NUM_KEYS       = 4,
  // Key index 0 sits in the least significant 16 bits: up, down, W, S.
  parameter logic [NUM_KEYS*16-1:0] KEY_CODES      = {16'h001B, 16'h001D, 16'hE072, 16'hE075},
  parameter int                     TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         byte_in,
  input  logic                               byte_valid,
  output logic [15:0]                        evt_code,
  output logic                               evt_break,
  output logic                               evt_valid,
  input  logic                               evt_ready,
  output logic [NUM_KEYS-1:0]                key_held,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  typedef struct packed {
    logic [15:0] code;
    logic        brk;
  } evt_t;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [2:0]          r_skip;
  logic [2:0]          w_skip_nxt;
  logic [TW-1:0]       r_tmo;
  logic                w_timeout;

  logic                w_emit;
  logic [15:0]         w_emit_code;
  logic                w_emit_brk;

  evt_t                r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic [NUM_KEYS-1:0] r_held;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  evt_t                w_head;

  // Bytes that carry no key meaning when seen outside a prefix sequence.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                                 is_ignored = 1'b0;
    endcase
  endfunction

  assign w_timeout = (r_state != S_IDLE) && !byte_valid &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_emit      = 1'b0;
    w_emit_code = 16'h0000;
    w_emit_brk  = 1'b0;
    if (byte_valid) begin
      case (r_state)
        S_IDLE: begin
          if (byte_in == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (byte_in == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (byte_in == 8'hE1) begin
            w_state_nxt = S_PAUSE;
            w_skip_nxt  = 3'd7;
          end else if (!is_ignored(byte_in)) begin
            w_emit      = 1'b1;
            w_emit_code = {8'h00, byte_in};
          end
        end
        S_EXT: begin
          if (byte_in == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else if (byte_in != 8'hE0) begin
            w_emit      = 1'b1;
            w_emit_code = {8'hE0, byte_in};
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (byte_in != 8'hF0) begin
            w_emit      = 1'b1;
            w_emit_code = {8'h00, byte_in};
            w_emit_brk  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (byte_in != 8'hF0) begin
            w_emit      = 1'b1;
            w_emit_code = {8'hE0, byte_in};
            w_emit_brk  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_PAUSE: begin
          // Pause is an 8-byte make-only sequence; only its last byte reports.
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_emit      = 1'b1;
            w_emit_code = 16'hE114;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_skip_nxt  = 3'd0;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_skip_nxt  = 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
      if (byte_valid || (r_state == S_IDLE) || w_timeout) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && evt_ready;
  assign w_push  = w_emit && (!w_full || w_pop);
  assign w_drop  = w_emit && w_full && !w_pop;

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= '{code: w_emit_code, brk: w_emit_brk};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Held state follows every decoded event, even one the full FIFO had to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_emit && (w_emit_code == KEY_CODES[16*i +: 16])) begin
          r_held[i] <= !w_emit_brk;
        end
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign evt_valid  = !w_empty;
  assign evt_code   = w_empty ? 16'h0000 : w_head.code;
  assign evt_break  = w_empty ? 1'b0 : w_head.brk;
  assign key_held   = r_held;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-code sequences plus a random
// byte stream, checked against a prefix-flag reference model.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int NK    = 4;
  localparam int T     = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic [15:0]   evt_code;
  logic          evt_break;
  logic          evt_valid;
  logic          evt_ready;
  logic [NK-1:0] key_held;
  logic          overflow;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .NUM_KEYS      (NK),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .key_held  (key_held),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [15:0] code;
    logic        brk;
  } evt_t;

  int          checks   = 0;
  int          failures = 0;
  evt_t        sb[$];
  logic [15:0] keys[NK] = '{16'hE075, 16'hE072, 16'h001D, 16'h001B};
  bit          m_ext;
  bit          m_brk;
  int          m_pause;
  int          m_idle;
  logic [NK-1:0] m_held;
  int          ready_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  task automatic model_reset();
    m_ext   = 0;
    m_brk   = 0;
    m_pause = 0;
    m_idle  = 0;
    m_held  = '0;
    sb.delete();
  endtask

  // Reference: prefix flags and a Pause byte countdown, applied byte by byte.
  task automatic model_byte(input logic [7:0] b, input bit can_push);
    bit          emit;
    logic [15:0] code;
    bit          brk;
    emit = 0;
    code = 16'h0;
    brk  = 0;
    if (m_idle >= T) begin
      m_ext   = 0;
      m_brk   = 0;
      m_pause = 0;
    end
    m_idle = 0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin
        emit = 1;
        code = 16'hE114;
      end
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0)      m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
        emit = 1;
        code = {8'h00, b};
      end
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!(b == 8'hE0 && m_ext && !m_brk)) begin
      emit  = 1;
      code  = {(m_ext ? 8'hE0 : 8'h00), b};
      brk   = m_brk;
      m_ext = 0;
      m_brk = 0;
    end
    if (emit) begin
      if (can_push) sb.push_back('{code: code, brk: brk});
      for (int i = 0; i < NK; i++) begin
        if (keys[i] == code) m_held[i] = !brk;
      end
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      m_idle++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit can_push = 1, input bit flow = 1);
    int n;
    n = 0;
    if (flow) begin
      while (fifo_count == 3'(DEPTH)) begin
        if (n >= 1000) begin
          fail("fifo_room_wait");
          break;
        end
        tick(1);
        n++;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    model_byte(b, can_push);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("key_held", 32'(key_held), 32'(m_held));
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while (sb.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    tick(2);
    check("fifo_count_drained", 32'(fifo_count), 32'd0);
  endtask

  // Ready driver: changes evt_ready 2 units after each rising edge.
  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: a pop happens at the next rising edge whenever valid && ready at the falling edge.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (evt_valid && evt_ready) begin
          if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL unexpected_event actual=%0h/%0b required=none t=%0t",
                     evt_code, evt_break, $time);
          end else begin
            e = sb.pop_front();
            check("evt_code", 32'(evt_code), 32'(e.code));
            check("evt_break", 32'(evt_break), 32'(e.brk));
          end
        end else if (!evt_valid) begin
          check("empty_head_zero", {15'd0, evt_break, evt_code}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[4] = '{8'h1D, 8'h1B, 8'h75, 8'h72};
    logic [7:0] b;
    int         r;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_code", 32'(evt_code), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(2);

    // W press and release
    send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
    drain();
    // Up arrow with a repeated E0 prefix on the release
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain();
    // Pause sequence, then an ordinary key proves the decoder is back in IDLE
    foreach (pool[i]) b = pool[i];
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h1C);
    drain();
    // Controller status bytes are dropped in IDLE
    send_byte(8'hAA); send_byte(8'hFA); send_byte(8'h00); send_byte(8'hEE);
    drain();

    // Latency: no combinational bypass, evt_valid one cycle after the byte
    ready_mode = 0;
    tick(1);
    byte_in    = 8'h1C;
    byte_valid = 1'b1;
    model_byte(8'h1C, 1);
    #1;
    check("no_bypass_valid", 32'(evt_valid), 32'd0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("latency_valid", 32'(evt_valid), 32'd1);
    check("latency_code", 32'(evt_code), 32'h001C);
    check("latency_count", 32'(fifo_count), 32'd1);
    drain();

    // Overflow: 5 makes into a 4-deep FIFO, then a dropped release still clears key_held
    ready_mode = 0;
    tick(1);
    send_byte(8'h1B, 1, 0); send_byte(8'h1C, 1, 0); send_byte(8'h23, 1, 0); send_byte(8'h24, 1, 0);
    send_byte(8'h2B, 0, 0);
    send_byte(8'hF0, 0, 0); send_byte(8'h1B, 0, 0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_code", 32'(evt_code), 32'h001B);
    check("ovf_head_break", 32'(evt_break), 32'd0);
    check("ovf_s_released", 32'(key_held[3]), 32'd0);
    // Push and pop together while full keeps the count at 4
    ready_mode = 1;
    send_byte(8'h2C, 1, 0);
    check("full_push_pop_count", 32'(fifo_count), 32'd4);
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Timeout boundary: T-1 idle cycles keep the prefix, T idle cycles drop it
    send_byte(8'hE0); tick(T - 1); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); tick(T); send_byte(8'h1B);
    send_byte(8'hF0); send_byte(8'h1B);
    send_byte(8'hE1); send_byte(8'h14); tick(T); send_byte(8'h1C);
    drain();

    // Reset mid-sequence, with byte_valid held during reset
    send_byte(8'h1D);
    drain();
    send_byte(8'hF0);
    rst        = 1'b1;
    byte_in    = 8'h1C;
    byte_valid = 1'b1;
    tick(2);
    byte_valid = 1'b0;
    rst        = 1'b0;
    model_reset();
    check("rst2_key_held", 32'(key_held), 32'd0);
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_count", 32'(fifo_count), 32'd0);
    send_byte(8'h1B);
    send_byte(8'hF0); send_byte(8'h1B);
    drain();

    // Random byte stream with random consumer back-pressure
    ready_mode = 2;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hF0;
      else if (r < 4) b = 8'hE0;
      else if (r < 5) b = 8'hE1;
      else if (r < 8) b = pool[$urandom_range(0, 3)];
      else            b = 8'($urandom_range(0, 255));
      send_byte(b);
      tick($urandom_range(0, 2));
    end
    drain();
    check("random_no_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
